cache_fill_fsm: RTL
===================

// Module: cache_fill_fsm
// PURPOSE
//  Miss handler directly upstream of the 64-set x 2-way x 8-word cache data array.
//  On a miss it fetches the 16-byte line from multi-cycle main memory, one word per request.
//  It drives the array's one-hot block/word enables and per-way write strobes so each
//  returning word is written into the victim way. On completion it pulses a tag-array update.
// PARAMETERS
//  ADDR_W   16  byte-address width; offset [3:1] word, index [9:4], tag [15:10]
//  SETS     64  sets in data array (width of blk_en)
//  WORDS    8   words per line (width of word_en, issue/return count target)
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  rst            in   1   synchronous, active-low reset
//  miss_detected  in   1   cache miss this cycle, sampled only in IDLE
//  miss_addr      in   16  byte address of missing access, sampled with miss_detected
//  victim_way     in   1   way to fill (0 -> way0, 1 -> way1), sampled with miss_detected
//  mem_ready      in   1   memory accepts a read request this cycle
//  mem_data       in   16  returned memory word
//  mem_data_valid in   1   mem_data valid; returns arrive in request order
//  fsm_busy       out  1   fill in progress (IDLE: 0)
//  mem_addr       out  16  read request address, word aligned
//  mem_rd_en      out  1   read request strobe
//  data_wr        out  2   per-way data-array write strobe (one-hot or 0)
//  blk_en         out  64  one-hot set select into data array
//  word_en        out  8   one-hot word select into data array
//  data_wr_word   out  16  word to write (= mem_data)
//  tag_wr         out  1   one-cycle tag/valid write pulse
//  tag_wr_way     out  2   one-hot way for tag write
//  tag_wr_tag     out  6   tag written = latched miss_addr[15:10]
// BEHAVIOUR
//  - States: IDLE, ISSUE, DRAIN, DONE. rst=0 at an edge -> IDLE, counters 0, latches 0.
//  - Reset value of every output: 0, including blk_en, word_en, data_wr and mem_addr.
//  - IDLE: miss_detected=1 at edge T latches miss_addr[15:4] and victim_way, clears
//    issue_cnt/ret_cnt, and moves to ISSUE. fsm_busy=1 from cycle T+1.
//  - ISSUE: mem_rd_en=1, mem_addr={line[15:4], issue_cnt[2:0], 1'b0}.
//    issue_cnt increments only on mem_ready=1. After 8th accepted request -> DRAIN
//    (or -> DONE if 8th return lands the same edge).
//  - DRAIN: mem_rd_en=0; wait for remaining returns.
//  - Return path, active in ISSUE and DRAIN, combinational in the cycle mem_data_valid=1:
//      data_wr[victim_way]=1, blk_en=1<<index, word_en=1<<ret_cnt,
//      data_wr_word=mem_data. ret_cnt increments at the edge.
//    Outputs are 0 when mem_data_valid=0.
//  - 8th return (ret_cnt 7->8) -> DONE. DONE lasts exactly 1 cycle:
//    tag_wr=1, tag_wr_way=1<<victim_way, tag_wr_tag latched; next state IDLE.
//    fsm_busy=1 in DONE.
//  - Minimum fill: mem latency L -> last data write at issue start + 7 + L; DONE on the next cycle.
//  - miss_detected while not IDLE: ignored, no relatch.
//  - mem_data_valid in IDLE or DONE: ignored, no writes.
//  - Returns beyond 8 are impossible by protocol; ret_cnt saturates at 8.
//  - Simultaneous accepted request and return in the same cycle: both counters advance.
//  - Reset mid-fill: immediate IDLE. The partially written line stays in the array but no
//    tag_wr is issued, so the line stays invalid. Late returns after reset are ignored.
//  - Counter widths: 4 bits (0..8); word index uses [2:0] only.
// TESTING
//  1. Reset: rst=0 for 2 cycles with random inputs -> all outputs 0, fsm_busy=0.
//  2. Miss addr=16'hA4C6, way1, mem_ready=1, latency 4 -> mem_addr A4C0,A4C2..A4CE;
//     8 writes with data_wr=2'b10, blk_en bit 12, word_en 01..80; one tag_wr with tag 6'h29.
//  3. mem_ready toggling 1,0,1,0... -> addresses issued without skip/duplicate; fill completes;
//     exactly 8 writes.
//  4. miss_detected re-asserted with a new address mid-fill -> ignored; all writes and the tag
//     use the original line.
//  5. rst=0 after 3 returns -> IDLE next cycle, no tag_wr. Later mem_data_valid produces no
//     data_wr. New miss fills correctly.
//  6. Back-to-back misses, way0 then way1, same index -> second fill starts the cycle after
//     DONE; data_wr=01 then 10.

Source files
------------

// File: rtl/cache_fill_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : cache_fill_fsm_if
//  Brief    : Miss-request, main-memory read and data/tag-array write bundle
//             for the cache line fill controller.
//  Revision : 1.0
// ============================================================================
interface cache_fill_fsm_if #(
    parameter int ADDR_W = 16,
    parameter int SETS   = 64,
    parameter int WORDS  = 8,
    parameter int DATA_W = 16
);
    localparam int c_TAG_W = ADDR_W - 1 - $clog2(WORDS) - $clog2(SETS);

    logic                miss_detected;
    logic [ADDR_W-1:0]   miss_addr;
    logic                victim_way;
    logic                mem_ready;
    logic [DATA_W-1:0]   mem_data;
    logic                mem_data_valid;
    logic                fsm_busy;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_rd_en;
    logic [1:0]          data_wr;
    logic [SETS-1:0]     blk_en;
    logic [WORDS-1:0]    word_en;
    logic [DATA_W-1:0]   data_wr_word;
    logic                tag_wr;
    logic [1:0]          tag_wr_way;
    logic [c_TAG_W-1:0]  tag_wr_tag;

    modport master (
        input  miss_detected, miss_addr, victim_way,
        input  mem_ready, mem_data, mem_data_valid,
        output fsm_busy, mem_addr, mem_rd_en,
        output data_wr, blk_en, word_en, data_wr_word,
        output tag_wr, tag_wr_way, tag_wr_tag
    );

    modport slave (
        output miss_detected, miss_addr, victim_way,
        output mem_ready, mem_data, mem_data_valid,
        input  fsm_busy, mem_addr, mem_rd_en,
        input  data_wr, blk_en, word_en, data_wr_word,
        input  tag_wr, tag_wr_way, tag_wr_tag
    );
endinterface
`default_nettype wire

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : cache_fill_fsm
//  Brief    : Cache miss handler: fetches one line word-by-word from memory,
//             writes each word into the victim way, then pulses a tag update.
//  Revision : 1.0
// ============================================================================
module cache_fill_fsm #(
    parameter int ADDR_W = 16,
    parameter int SETS   = 64,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    cache_fill_fsm_if.master  fill_if
);
    localparam int c_WORD_W  = $clog2(WORDS);
    localparam int c_IDX_W   = $clog2(SETS);
    localparam int c_IDX_LSB = 1 + c_WORD_W;
    localparam int c_LINE_W  = ADDR_W - c_IDX_LSB;
    localparam int c_TAG_W   = ADDR_W - c_IDX_LSB - c_IDX_W;
    localparam int c_CNT_W   = c_WORD_W + 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WORDS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(WORDS);
    localparam logic [SETS-1:0]    c_SET_ONE  = SETS'(1);
    localparam logic [WORDS-1:0]   c_WORD_ONE = WORDS'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_q,     state_d;
    logic [c_LINE_W-1:0]  line_q,      line_d;
    logic                 way_q,       way_d;
    logic [c_CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [c_CNT_W-1:0]   ret_cnt_q,   ret_cnt_d;
    logic                 w_ret;
    logic                 w_unused_addr_lsb;

    // Byte/word offset of the miss address is irrelevant: the whole line is fetched.
    assign w_unused_addr_lsb = ^fill_if.miss_addr[c_IDX_LSB-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            line_q      <= '0;
            way_q       <= 1'b0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            way_q       <= way_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        line_d               = line_q;
        way_d                = way_q;
        issue_cnt_d          = issue_cnt_q;
        ret_cnt_d            = ret_cnt_q;
        w_ret                = 1'b0;
        fill_if.fsm_busy     = (state_q != ST_IDLE);
        fill_if.mem_addr     = '0;
        fill_if.mem_rd_en    = 1'b0;
        fill_if.data_wr      = 2'b00;
        fill_if.blk_en       = '0;
        fill_if.word_en      = '0;
        fill_if.data_wr_word = '0;
        fill_if.tag_wr       = 1'b0;
        fill_if.tag_wr_way   = 2'b00;
        fill_if.tag_wr_tag   = '0;

        case (state_q)
            ST_IDLE: begin
                if (fill_if.miss_detected) begin
                    line_d      = fill_if.miss_addr[ADDR_W-1:c_IDX_LSB];
                    way_d       = fill_if.victim_way;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fill_if.mem_rd_en = 1'b1;
                fill_if.mem_addr  = {line_q, issue_cnt_q[c_WORD_W-1:0], 1'b0};
                w_ret             = fill_if.mem_data_valid;
                if (fill_if.mem_ready) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_q == c_CNT_LAST) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                w_ret = fill_if.mem_data_valid;
            end
            ST_DONE: begin
                fill_if.tag_wr     = 1'b1;
                fill_if.tag_wr_way = way_q ? 2'b10 : 2'b01;
                fill_if.tag_wr_tag = line_q[c_LINE_W-1 -: c_TAG_W];
                state_d            = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The final return overrides a same-edge ISSUE->DRAIN move and finishes the fill.
        if (w_ret && (ret_cnt_q != c_CNT_FULL)) begin
            fill_if.data_wr      = way_q ? 2'b10 : 2'b01;
            fill_if.blk_en       = c_SET_ONE << line_q[c_IDX_W-1:0];
            fill_if.word_en      = c_WORD_ONE << ret_cnt_q[c_WORD_W-1:0];
            fill_if.data_wr_word = fill_if.mem_data;
            ret_cnt_d            = ret_cnt_q + 1'b1;
            if (ret_cnt_q == c_CNT_LAST) begin
                state_d = ST_DONE;
            end
        end
    end
endmodule
`default_nettype wire
